vending_machine_core: RTL and testbench
=======================================

VENDING_MACHINE_CORE -- requirements
Module: vending_machine

Interface
REQ-001 clk  input  1  System clock; all state changes on rising edge.
REQ-002 rstn  input  1  Reset; asynchronous, active-high (rstn=1 resets) despite the name.
REQ-003 coin  input  2  Coin per sampled edge: 00 none, 01 = 1 unit (0.5 yuan), 10 = 2 units (1 yuan), 11 illegal (ignored).
REQ-004 goods  input  2  Product select: 00 no change, 01 = item A (price 2 units), 10 = item B (price 3 units), 11 = item C (price 4 units).
REQ-005 key  input  1  Cancel/refund request, active-high, level-sampled each edge.
REQ-006 change  output  2  Registered payout coin per cycle: 00 none, 01 one 1-unit coin, 10 one 2-unit coin; 11 never driven.
REQ-007 sell  output  1  Registered one-cycle pulse: selected item dispensed.

Function
REQ-008 The block SHALL hold a 3-bit credit register (0..7 units), a 2-bit selection register sel, a 3-bit remaining-payout register, and a two-state FSM: COLLECT, PAYOUT.
REQ-009 In COLLECT, each edge SHALL apply exactly one action, in priority order: cancel, vend, coin/select update.
REQ-010 Cancel: key=1 and credit>0 SHALL load remaining=credit, clear credit and sel, and enter PAYOUT; key=1 with credit=0 SHALL do nothing.
REQ-011 Vend: sel!=00 and credit>=price(sel) SHALL assert sell=1 for the next cycle only, load remaining=credit-price, clear credit and sel, and enter PAYOUT if remaining>0, else stay in COLLECT.
REQ-012 Otherwise, coin 01/10 SHALL add its value to credit unless the sum exceeds 7, in which case the coin is rejected and credit is unchanged; coin 11 SHALL be ignored.
REQ-013 Otherwise, goods!=00 SHALL load sel=goods (reselection allowed); goods=00 SHALL retain sel.
REQ-014 Vend evaluation SHALL use registered credit and sel, so a coin or selection takes effect one edge before it can trigger a vend; minimum latency from the completing coin edge to sell high is one cycle.
REQ-015 Inputs arriving in the same cycle as a cancel or vend (coin, goods) SHALL be discarded.
REQ-016 In PAYOUT, each edge SHALL drive change=10 and subtract 2 if remaining>=2, else change=01 and subtract 1; on the edge where remaining reaches 0, change SHALL be driven for that final cycle and the FSM SHALL return to COLLECT.
REQ-017 In PAYOUT, coin, goods and key SHALL be ignored and their inserted coins are not credited.
REQ-018 change SHALL be 00 and sell SHALL be 0 in every cycle not covered by REQ-011/REQ-016.

Reset
REQ-019 rstn=1 SHALL immediately force FSM=COLLECT, credit=0, sel=00, remaining=0, change=00, sell=0, independent of clk.
REQ-020 Reset asserted mid-PAYOUT SHALL abort the payout; the outstanding remainder is lost.
REQ-021 After release, the first rising edge with rstn=0 SHALL perform normal COLLECT processing.

Verification
REQ-022 Reset, one coin=01 edge, then goods=10 held, key=0 -> credit=1, sel=10, sell stays 0, change stays 00.
REQ-023 coin=10, coin=10 on two edges, goods=01 -> one cycle of sell=1, credit -> 0, then one cycle change=10, then back to COLLECT.
REQ-024 Credit 3 (01,10), goods=11, then key=1 -> no sell; payout change=10 then change=01 on consecutive cycles; credit 0.
REQ-025 Credit 6 (10,10,10), coin=10 again -> coin rejected, credit stays 6; goods=10 -> sell pulse, then change=10, change=01.
REQ-026 Credit 4 selecting item C -> sell pulse with no change cycles; key and coin asserted in PAYOUT of another case -> ignored.
REQ-027 rstn asserted between clock edges during PAYOUT -> change=00, sell=0 immediately; credit 0 after release.

Source files
------------

// File: rtl/vending_machine_core.sv
// Vending machine core: accumulates coin credit, vends the selected item, and
// pays change back one coin per cycle.
module vending_machine_core (
  input  logic       clk_i,
  input  logic       rstn_i,   // active-high asynchronous reset despite the name
  input  logic [1:0] coin_i,
  input  logic [1:0] goods_i,
  input  logic       key_i,
  output logic [1:0] change_o,
  output logic       sell_o
);

  typedef enum logic {COLLECT = 1'b0, PAYOUT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [2:0] credit_q, credit_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] remain_q, remain_d;
  logic [1:0] change_q, change_d;
  logic       sell_q, sell_d;

  logic [2:0] price;
  logic [3:0] coin_sum;

  always_comb begin
    unique case (sel_q)
      2'b01:   price = 3'd2;
      2'b10:   price = 3'd3;
      2'b11:   price = 3'd4;
      default: price = 3'd0;
    endcase
  end

  // One bit wider so a coin that would overflow the 3-bit credit is detectable.
  assign coin_sum = {1'b0, credit_q} + {2'b00, coin_i};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    sel_d    = sel_q;
    remain_d = remain_q;
    change_d = 2'b00;
    sell_d   = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (key_i) begin
          // A cancel with no credit is a no-op, and it still takes the cycle.
          if (credit_q != 3'd0) begin
            remain_d = credit_q;
            credit_d = 3'd0;
            sel_d    = 2'b00;
            state_d  = PAYOUT;
          end
        end else if (sel_q != 2'b00 && credit_q >= price) begin
          sell_d   = 1'b1;
          remain_d = credit_q - price;
          credit_d = 3'd0;
          sel_d    = 2'b00;
          if (credit_q != price) state_d = PAYOUT;
        end else begin
          if ((coin_i == 2'b01 || coin_i == 2'b10) && coin_sum <= 4'd7)
            credit_d = coin_sum[2:0];
          if (goods_i != 2'b00) sel_d = goods_i;
        end
      end
      PAYOUT: begin
        if (remain_q >= 3'd2) begin
          change_d = 2'b10;
          remain_d = remain_q - 3'd2;
        end else begin
          change_d = 2'b01;
          remain_d = (remain_q == 3'd0) ? 3'd0 : remain_q - 3'd1;
        end
        if (remain_d == 3'd0) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rstn_i) begin
    if (rstn_i) begin
      state_q  <= COLLECT;
      credit_q <= 3'd0;
      sel_q    <= 2'b00;
      remain_q <= 3'd0;
      change_q <= 2'b00;
      sell_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      sel_q    <= sel_d;
      remain_q <= remain_d;
      change_q <= change_d;
      sell_q   <= sell_d;
    end
  end

  assign change_o = change_q;
  assign sell_o   = sell_q;

endmodule

// File: tb/tb_vending_machine_core.sv
// Directed bench for vending_machine_core: credit, vend, cancel, payout, reset.
module tb_vending_machine_core;

  logic       clk;
  logic       rstn;
  logic [1:0] coin;
  logic [1:0] goods;
  logic       key;
  logic [1:0] change;
  logic       sell;

  int checks = 0;
  int errors = 0;

  vending_machine_core dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .coin_i  (coin),
    .goods_i (goods),
    .key_i   (key),
    .change_o(change),
    .sell_o  (sell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the currently driven inputs to one rising edge, then settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin = 2'b00; goods = 2'b00; key = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rstn = 1'b1;
    #2;
    @(negedge clk);
    rstn = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b1;
    #2;
    checks++;
    if (change !== 2'b00 || sell !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: change=%b sell=%b, required change=00 sell=0", change, sell);
    end
    @(negedge clk);
    rstn = 1'b0;
    checks++;
    if (dut.credit_q !== 3'd0 || dut.sel_q !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: credit=%0d sel=%b, required credit=0 sel=00", dut.credit_q, dut.sel_q);
    end
  endtask

  task automatic test_coin_select();
    do_reset();
    coin = 2'b01; step();
    coin = 2'b00; goods = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sell !== 1'b0 || change !== 2'b00) begin
        errors++;
        $display("FAIL coin_select_idle[%0d]: sell=%b change=%b, required sell=0 change=00", i, sell, change);
      end
    end
    checks++;
    if (dut.credit_q !== 3'd1 || dut.sel_q !== 2'b10) begin
      errors++;
      $display("FAIL coin_select_state: credit=%0d sel=%b, required credit=1 sel=10", dut.credit_q, dut.sel_q);
    end
    // Illegal coin value must leave credit alone.
    goods = 2'b00; coin = 2'b11; step();
    checks++;
    if (dut.credit_q !== 3'd1) begin
      errors++;
      $display("FAIL coin_illegal: credit=%0d, required 1", dut.credit_q);
    end
  endtask

  task automatic test_vend_change();
    do_reset();
    coin = 2'b10; step();
    coin = 2'b10; step();
    coin = 2'b00; goods = 2'b01; step();
    goods = 2'b00; step();
    checks++;
    if (sell !== 1'b1 || change !== 2'b00 || dut.credit_q !== 3'd0) begin
      errors++;
      $display("FAIL vend_a_sell: sell=%b change=%b credit=%0d, required 1 00 0", sell, change, dut.credit_q);
    end
    step();
    checks++;
    if (sell !== 1'b0 || change !== 2'b10) begin
      errors++;
      $display("FAIL vend_a_change: sell=%b change=%b, required 0 10", sell, change);
    end
    step();
    checks++;
    if (sell !== 1'b0 || change !== 2'b00) begin
      errors++;
      $display("FAIL vend_a_done: sell=%b change=%b, required 0 00", sell, change);
    end
  endtask

  task automatic test_cancel();
    logic [1:0] exp_chg [3];
    exp_chg[0] = 2'b10; exp_chg[1] = 2'b01; exp_chg[2] = 2'b00;
    do_reset();
    coin = 2'b01; step();
    coin = 2'b10; step();
    coin = 2'b00; goods = 2'b11; step();
    goods = 2'b00; key = 1'b1; step();
    checks++;
    if (sell !== 1'b0 || change !== 2'b00 || dut.credit_q !== 3'd0) begin
      errors++;
      $display("FAIL cancel_edge: sell=%b change=%b credit=%0d, required 0 00 0", sell, change, dut.credit_q);
    end
    key = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sell !== 1'b0 || change !== exp_chg[i]) begin
        errors++;
        $display("FAIL cancel_payout[%0d]: sell=%b change=%b, required 0 %b", i, sell, change, exp_chg[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [1:0] exp_chg [3];
    exp_chg[0] = 2'b10; exp_chg[1] = 2'b01; exp_chg[2] = 2'b00;
    do_reset();
    coin = 2'b10; step(); step(); step();
    step();
    checks++;
    if (dut.credit_q !== 3'd6) begin
      errors++;
      $display("FAIL overflow_reject: credit=%0d, required 6", dut.credit_q);
    end
    coin = 2'b00; goods = 2'b10; step();
    goods = 2'b00; step();
    checks++;
    if (sell !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sell: sell=%b, required 1", sell);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sell !== 1'b0 || change !== exp_chg[i]) begin
        errors++;
        $display("FAIL overflow_payout[%0d]: sell=%b change=%b, required 0 %b", i, sell, change, exp_chg[i]);
      end
    end
  endtask

  task automatic test_exact_and_ignore();
    logic [1:0] exp_chg [4];
    exp_chg[0] = 2'b10; exp_chg[1] = 2'b10; exp_chg[2] = 2'b01; exp_chg[3] = 2'b00;
    do_reset();
    coin = 2'b10; step(); step();
    coin = 2'b00; goods = 2'b11; step();
    goods = 2'b00; step();
    checks++;
    if (sell !== 1'b1 || change !== 2'b00) begin
      errors++;
      $display("FAIL exact_sell: sell=%b change=%b, required 1 00", sell, change);
    end
    step();
    checks++;
    if (sell !== 1'b0 || change !== 2'b00) begin
      errors++;
      $display("FAIL exact_nochange: sell=%b change=%b, required 0 00", sell, change);
    end
    // Credit 7, buy A -> 5 units back; inputs during payout must be ignored.
    coin = 2'b10; step(); step(); step();
    coin = 2'b01; step();
    coin = 2'b00; goods = 2'b01; step();
    goods = 2'b00; step();
    checks++;
    if (sell !== 1'b1) begin
      errors++;
      $display("FAIL ignore_sell: sell=%b, required 1", sell);
    end
    key = 1'b1; coin = 2'b10; goods = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sell !== 1'b0 || change !== exp_chg[i]) begin
        errors++;
        $display("FAIL ignore_payout[%0d]: sell=%b change=%b, required 0 %b", i, sell, change, exp_chg[i]);
      end
    end
    idle_inputs(); step();
    checks++;
    if (change !== exp_chg[3] || dut.credit_q !== 3'd0 || dut.sel_q !== 2'b00) begin
      errors++;
      $display("FAIL ignore_after: change=%b credit=%0d sel=%b, required 00 0 00", change, dut.credit_q, dut.sel_q);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    goods = 2'b01; step();
    goods = 2'b00; coin = 2'b10; step();
    checks++;
    if (sell !== 1'b0 || dut.credit_q !== 3'd2) begin
      errors++;
      $display("FAIL b2b_coin_edge: sell=%b credit=%0d, required 0 2", sell, dut.credit_q);
    end
    // Coin and selection arriving on the vend edge are discarded.
    coin = 2'b01; goods = 2'b10; step();
    checks++;
    if (sell !== 1'b1 || dut.credit_q !== 3'd0 || dut.sel_q !== 2'b00) begin
      errors++;
      $display("FAIL b2b_vend: sell=%b credit=%0d sel=%b, required 1 0 00", sell, dut.credit_q, dut.sel_q);
    end
    idle_inputs(); step();
    checks++;
    if (sell !== 1'b0 || change !== 2'b00) begin
      errors++;
      $display("FAIL b2b_after: sell=%b change=%b, required 0 00", sell, change);
    end
  endtask

  task automatic test_reset_mid_payout();
    do_reset();
    coin = 2'b10; step(); step(); step();
    coin = 2'b00; key = 1'b1; step();
    key = 1'b0; step();
    checks++;
    if (change !== 2'b10) begin
      errors++;
      $display("FAIL midrst_pre: change=%b, required 10", change);
    end
    #2;
    rstn = 1'b1;
    #1;
    checks++;
    if (change !== 2'b00 || sell !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: change=%b sell=%b, required 00 0", change, sell);
    end
    @(negedge clk);
    rstn = 1'b0;
    step();
    checks++;
    if (change !== 2'b00 || dut.credit_q !== 3'd0) begin
      errors++;
      $display("FAIL midrst_release: change=%b credit=%0d, required 00 0", change, dut.credit_q);
    end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_coin_select();
    test_vend_change();
    test_cancel();
    test_overflow();
    test_exact_and_ignore();
    test_back_to_back();
    test_reset_mid_payout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
